// File: rtl/psum_ofifo_pkg.sv
// psum_ofifo_pkg: shared defaults and helpers for the PE-array output collector
package psum_ofifo_pkg;
  localparam int col_d = 8;
  localparam int psum_bw_d = 16;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int col_lo(input int i, input int bw);
    return i * bw;
  endfunction
endpackage

// File: rtl/psum_ofifo_col.sv
// psum_ofifo_col: single-column psum FIFO with show-ahead head output
// ports: clk, reset (async, active-high); wr/din push; rd pops (caller guarantees non-empty);
//        dout = head slot; empty/full from pointers only; overflow = sticky dropped-write flag
module psum_ofifo_col
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = psum_bw_d,
  parameter int depth = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               rd,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               overflow
);
  localparam int pw = ptr_w(depth);
  localparam int aw = pw - 1;
  localparam logic [pw-1:0] one = 1;
  logic [psum_bw-1:0] mem [depth];
  logic [pw-1:0] wptr, rptr;
  assign empty = rptr == wptr;
  assign full = (rptr[aw-1:0] == wptr[aw-1:0]) && (rptr[aw] != wptr[aw]);
  assign dout = mem[rptr[aw-1:0]];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < depth; k++) mem[k] <= '0;
    end else begin
      if (wr && !full) begin
        mem[wptr[aw-1:0]] <= din;
        wptr <= wptr + one;
      end
      if (wr && full) overflow <= 1'b1;
      if (rd) rptr <= rptr + one;
    end
  end
endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column psum FIFOs that present a full row only when every column has data
// ports: clk, reset (async, active-high); in/wr from the array south edge (column i at in[i*psum_bw +: psum_bw]);
//        rd pops a whole row; out = column heads; o_valid = all non-empty; o_full = any full;
//        o_ready = !o_full; overflow = sticky per-column dropped-write flags
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col = col_d,
  parameter int psum_bw = psum_bw_d,
  parameter int depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic [col-1:0]         overflow
);
  logic [col-1:0] empty, full;
  assign o_valid = ~|empty;
  assign o_full = |full;
  assign o_ready = ~o_full;
  for (genvar i = 0; i < col; i++) begin : g_col
    psum_ofifo_col #(.psum_bw(psum_bw), .depth(depth)) u_col (
      .clk(clk),
      .reset(reset),
      .wr(wr[i]),
      .din(in[col_lo(i, psum_bw) +: psum_bw]),
      .rd(rd & o_valid),
      .dout(out[col_lo(i, psum_bw) +: psum_bw]),
      .empty(empty[i]),
      .full(full[i]),
      .overflow(overflow[i])
    );
  end
endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: randomized and directed checks of psum_ofifo against per-column queue model
module tb_psum_ofifo;
  localparam int C = 8;
  localparam int W = 16;
  localparam int D = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W*C-1:0] in = '0;
  logic [C-1:0] wr = '0;
  logic rd = 1'b0;
  logic [W*C-1:0] out;
  logic o_valid, o_full, o_ready;
  logic [C-1:0] overflow;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] q [C][$];
  logic [C-1:0] m_ovf = '0;
  psum_ofifo #(.col(C), .psum_bw(W), .depth(D)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W*C-1:0] obs, input logic [W*C-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit m_valid();
    for (int i = 0; i < C; i++) if (q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit m_full();
    for (int i = 0; i < C; i++) if (q[i].size() == D) return 1'b1;
    return 1'b0;
  endfunction
  task automatic check(input string tag);
    logic [W*C-1:0] exp;
    chk({tag, ".valid"}, o_valid, m_valid());
    chk({tag, ".full"}, o_full, m_full());
    chk({tag, ".ready"}, o_ready, !m_full());
    chk({tag, ".ovf"}, overflow, m_ovf);
    if (m_valid()) begin
      for (int i = 0; i < C; i++) exp[i*W +: W] = q[i][0];
      chk({tag, ".out"}, out, exp);
    end
  endtask
  task automatic tick(input string tag);
    bit v;
    logic [C-1:0] fpre;
    v = m_valid();
    for (int i = 0; i < C; i++) fpre[i] = q[i].size() == D;
    for (int i = 0; i < C; i++) begin
      if (rd && v) void'(q[i].pop_front());
      if (wr[i] && !fpre[i]) q[i].push_back(in[i*W +: W]);
      if (wr[i] && fpre[i]) m_ovf[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    check(tag);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < C; i++) q[i].delete();
    m_ovf = '0;
    #1;
    check("reset");
    chk("reset.out", out, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    int pops;
    int r;
    logic [W*C-1:0] exp_row;
    do_reset();
    // async reset mid-burst
    wr = '1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < C; i++) in[i*W +: W] = W'($urandom);
      tick("burst");
    end
    wr = '0;
    #2;
    reset = 1'b1;
    for (int i = 0; i < C; i++) q[i].delete();
    m_ovf = '0;
    #1;
    chk("async.valid", o_valid, 1'b0);
    chk("async.ready", o_ready, 1'b1);
    chk("async.ovf", overflow, '0);
    chk("async.out", out, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd = 1'b1;
    tick("rd_empty");
    rd = 1'b0;
    // skewed fill
    for (int c = 0; c < C; c++) begin
      wr = '0;
      wr[c] = 1'b1;
      in[c*W +: W] = 16'h0100 + W'(c);
      tick("skew");
    end
    wr = '0;
    for (int i = 0; i < C; i++) exp_row[i*W +: W] = 16'h0100 + W'(i);
    chk("skew.row", out, exp_row);
    chk("skew.valid", o_valid, 1'b1);
    rd = 1'b1;
    tick("skew_pop");
    rd = 1'b0;
    // ordered drain with mixed skews
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < C; i++) begin
        r = c - (i * 3) % 5;
        wr[i] = r >= 0 && r < 4;
        in[i*W +: W] = W'(r * 16 + i);
      end
      tick("drain_fill");
    end
    wr = '0;
    rd = 1'b1;
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_valid) pops++;
      tick("drain");
    end
    rd = 1'b0;
    chk("drain.pops", pops, 4);
    // full / overflow on column 2
    do_reset();
    wr = 8'b0000_0100;
    for (int k = 1; k <= 17; k++) begin
      in[2*W +: W] = W'($urandom);
      tick("fill2");
      if (k == 16) begin
        chk("fill2.full", o_full, 1'b1);
        chk("fill2.ready", o_ready, 1'b0);
      end
    end
    wr = '0;
    chk("fill2.ovf", overflow, 8'b0000_0100);
    // simultaneous push and pop
    do_reset();
    wr = '1;
    for (int i = 0; i < C; i++) in[i*W +: W] = W'($urandom);
    tick("pp_seed");
    rd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < C; i++) in[i*W +: W] = W'($urandom);
      tick("pushpop");
      chk("pushpop.valid", o_valid, 1'b1);
    end
    wr = '0;
    rd = 1'b0;
    chk("pushpop.ovf", overflow, '0);
    // random interleaving across pointer wrap
    do_reset();
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < C; i++) begin
        wr[i] = ($urandom_range(0, 9) < 6) && q[i].size() < D;
        in[i*W +: W] = W'($urandom);
      end
      rd = $urandom_range(0, 9) < 4;
      tick("rand");
    end
    wr = '0;
    rd = 1'b0;
    chk("rand.ovf", overflow, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
